// File: rtl/bfloat16_div_seq.sv
// Sequential bfloat16 divider: 9-step restoring mantissa division, truncating
// normalization, fixed 10-cycle latency from accept to done.
module bfloat16_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] out,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic [15:0] a_r, b_r;
  logic [9:0]  rem;
  logic [8:0]  q;

  logic [7:0]  mb;
  logic        q_bit;
  logic [9:0]  rem_sub;
  logic [9:0]  e, e_m1;
  logic        sign;
  logic [15:0] result;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_DIV;
      S_DIV:   if (cnt == 4'd8) state_next = S_NORM;
      S_NORM:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Restoring step and result assembly; rem stays below 2*mb so 9 bits suffice.
  always_comb begin
    mb      = {1'b1, b_r[6:0]};
    q_bit   = (rem >= {2'b00, mb});
    rem_sub = q_bit ? (rem - {2'b00, mb}) : rem;
    e       = {2'b00, a_r[14:7]} - {2'b00, b_r[14:7]} + 10'd127;
    e_m1    = e - 10'd1;
    sign    = a_r[15] ^ b_r[15];
    if (b_r[14:7] == 8'h00)
      result = {sign, 8'hFF, 7'h00};
    else if (a_r[14:7] == 8'h00)
      result = {sign, 15'h0000};
    else if (q[8])
      result = {sign, e[7:0], q[7:1]};
    else
      result = {sign, e_m1[7:0], q[6:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      out         <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      q           <= '0;
      rem         <= '0;
      a_r         <= '0;
      b_r         <= '0;
    end else begin
      busy <= (state_next != S_IDLE);
      done <= (state == S_NORM);
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r <= a;
            b_r <= b;
            rem <= {2'b00, 1'b1, a[6:0]};
            q   <= '0;
            cnt <= '0;
          end
        end
        S_DIV: begin
          q   <= {q[7:0], q_bit};
          rem <= {rem_sub[8:0], 1'b0};
          cnt <= cnt + 4'd1;
        end
        S_NORM: begin
          out         <= result;
          div_by_zero <= (b_r[14:7] == 8'h00);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bfloat16_div_seq.sv
// Self-checking bench for bfloat16_div_seq: directed spec cases, handshake
// corner cases and random operands against an integer-arithmetic model.
module tb_bfloat16_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done;
  logic [15:0] out;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;
  int exp_done = 0;

  always #5 clk = ~clk;

  bfloat16_div_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .out(out), .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference: real-valued quotient of 1.m mantissas, truncated to 8 fraction bits.
  function automatic logic [16:0] ref_div(input logic [15:0] x, input logic [15:0] y);
    int ea, eb, ma, mb, qv, ex, man;
    logic s;
    ea = int'(x[14:7]);
    eb = int'(y[14:7]);
    s  = x[15] ^ y[15];
    if (eb == 0) return {1'b1, s, 8'hFF, 7'h00};
    if (ea == 0) return {1'b0, s, 15'h0000};
    ma = 128 + int'(x[6:0]);
    mb = 128 + int'(y[6:0]);
    qv = (ma * 256) / mb;
    if (qv >= 256) begin
      man = (qv / 2) % 128;
      ex  = ea - eb + 127;
    end else begin
      man = qv % 128;
      ex  = ea - eb + 126;
    end
    ex = ((ex % 256) + 256) % 256;
    return {1'b0, s, ex[7:0], man[6:0]};
  endfunction

  always @(posedge clk) if (done === 1'b1) done_seen++;

  always @(negedge clk) if (rst === 1'b0) check("busy_done_excl", {31'b0, busy & done}, 32'd0);

  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_in,
                       input logic [15:0] want_out, input logic want_dbz,
                       input bit poke, input bit at_neg);
    if (!at_neg) @(negedge clk);
    a = ta; b = tb_in; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_done++;
    a = 16'($urandom); b = 16'($urandom);
    check("accept_busy", {busy, done}, 2'b10);
    for (int i = 1; i < 10; i++) begin
      if (poke && i == 3) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_hold", {busy, done}, 2'b10);
    end
    @(posedge clk); #1;
    check("done_pulse", {busy, done}, 2'b01);
    check("out", out, want_out);
    check("dbz", div_by_zero, want_dbz);
    @(posedge clk); #1;
    check("done_clear", {busy, done}, 2'b00);
    check("out_hold", out, want_out);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] r;
    logic [15:0] ra, rb;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out", out, 16'h0000);
    check("rst_dbz", div_by_zero, 1'b0);

    // First start accepted on the very first edge with rst low.
    @(negedge clk);
    rst = 1'b0;
    do_op(16'h3F80, 16'h3F80, 16'h3F80, 1'b0, 1'b0, 1'b1);
    do_op(16'h40C0, 16'h4000, 16'h4040, 1'b0, 1'b1, 1'b0);
    do_op(16'hBFC0, 16'h3F00, 16'hC040, 1'b0, 1'b0, 1'b0);
    do_op(16'h3F80, 16'h4040, 16'h3EAA, 1'b0, 1'b0, 1'b0);
    do_op(16'h3F80, 16'h0000, 16'h7F80, 1'b1, 1'b0, 1'b0);
    do_op(16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0);
    do_op(16'h0000, 16'h8000, 16'hFF80, 1'b1, 1'b0, 1'b0);

    // Start held high through the done cycle: second op accepted at N+11.
    @(negedge clk);
    a = 16'h40C0; b = 16'h4000; start = 1'b1;
    @(posedge clk); #1;
    exp_done++;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("b2b_done1", {busy, done}, 2'b01);
    check("b2b_out1", out, 16'h4040);
    a = 16'h3F80; b = 16'h4040;
    @(posedge clk); #1;
    start = 1'b0;
    exp_done++;
    check("b2b_accept2", {busy, done}, 2'b10);
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("b2b_done2", {busy, done}, 2'b01);
    check("b2b_out2", out, 16'h3EAA);
    @(posedge clk); #1;

    // Reset at N+5 aborts the operation with no done pulse.
    @(negedge clk);
    a = 16'h3F80; b = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_out", out, 16'h0000);
    check("abort_dbz", div_by_zero, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_done", done_seen, exp_done);
    do_op(16'hBFC0, 16'h3F00, 16'hC040, 1'b0, 1'b0, 1'b0);

    // Random non-special operands.
    for (int n = 0; n < 60; n++) begin
      ra = {1'($urandom), 8'($urandom_range(1, 254)), 7'($urandom)};
      rb = {1'($urandom), 8'($urandom_range(1, 254)), 7'($urandom)};
      r  = ref_div(ra, rb);
      do_op(ra, rb, r[15:0], r[16], bit'(($urandom % 4) == 0), 1'b0);
    end

    check("done_count", done_seen, exp_done);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
